// File: rtl/reg_shift_tx_if.sv
// reg_shift_tx_if
//   Handshake and data bundle for the reg_shift_tx serial transmitter.
//
//   Parameter
//     N      word width in bits (N >= 2)
//
//   Signals
//     l      load request from the producer
//     d      parallel word to transmit (N bits)
//     ready  transmitter idle, a load will be accepted
//     sout   serial data bit
//     valid  sout carries a word bit
//     done   one-cycle pulse after the last bit of a word
//     q      copy of the last accepted word (N bits)
//
//   Modports
//     master  producer side: drives l/d, observes the transmitter outputs
//     slave   transmitter side: observes l/d, drives the outputs
interface reg_shift_tx_if #(
  parameter int N = 8
);

  logic         l;
  logic [N-1:0] d;
  logic         ready;
  logic         sout;
  logic         valid;
  logic         done;
  logic [N-1:0] q;

  modport master (
    output l,
    output d,
    input  ready,
    input  sout,
    input  valid,
    input  done,
    input  q
  );

  modport slave (
    input  l,
    input  d,
    output ready,
    output sout,
    output valid,
    output done,
    output q
  );

endinterface

// File: rtl/reg_shift_tx.sv
// reg_shift_tx
//   Parallel-in / serial-out word transmitter. A word presented on bus.d is
//   accepted while the block is idle and bus.l is high; its N bits are then
//   driven on bus.sout one per clock with bus.valid high, followed by a
//   single idle cycle in which bus.done pulses. A copy of the accepted word
//   is held on bus.q until the next accept.
//
//   Parameter
//     N            word width in bits (N >= 2)
//
//   Ports
//     ck           system clock, all state updates on the rising edge
//     rst          synchronous, active-high reset (wins over a load)
//     bus          reg_shift_tx_if.slave: l, d in; ready, sout, valid,
//                  done, q out (all outputs are registered)
//
//   Build option
//     LSB_FIRST_EN  when defined, words are sent LSB first (d[0] first);
//                   otherwise MSB first (d[N-1] first). Timing is the same
//                   in both builds.
module reg_shift_tx #(
  parameter int N = 8
) (
  input logic          ck,
  input logic          rst,
  reg_shift_tx_if.slave bus
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit that leaves the register first, for the configured bit order.
  function automatic logic head_bit(input logic [N-1:0] w);
`ifdef LSB_FIRST_EN
    return w[0];
`else
    return w[N-1];
`endif
  endfunction

  // Register contents after one bit has been sent.
  function automatic logic [N-1:0] advance(input logic [N-1:0] w);
`ifdef LSB_FIRST_EN
    return {1'b0, w[N-1:1]};
`else
    return {w[N-2:0], 1'b0};
`endif
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [N-1:0]    shreg_r;
  logic [N-1:0]    shreg_s;
  logic [N-1:0]    shreg_adv_s;
  logic [N-1:0]    q_r;
  logic [N-1:0]    q_s;
  logic            sout_r;
  logic            sout_s;
  logic            valid_r;
  logic            valid_s;
  logic            done_r;
  logic            done_s;
  logic            ready_r;
  logic            ready_s;

  // The head of the register always holds the bit currently on sout, so the
  // next bit to send is the head of the advanced register.
  assign shreg_adv_s = advance(shreg_r);

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every output comes straight from a flop.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shreg_s = shreg_r;
    q_s     = q_r;
    sout_s  = 1'b0;
    valid_s = 1'b0;
    done_s  = 1'b0;
    ready_s = 1'b1;

    case (state_r)
      IDLE: begin
        if (bus.l) begin
          // The first bit goes out right after the accepting edge.
          state_s = SHIFT;
          cnt_s   = {CW{1'b0}};
          shreg_s = bus.d;
          q_s     = bus.d;
          sout_s  = head_bit(bus.d);
          valid_s = 1'b1;
          ready_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
        if (cnt_r == LAST) begin
          // Last bit has been on sout for its cycle: return to idle and
          // flag completion in the same cycle that ready comes back.
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
          done_s  = 1'b1;
          ready_s = 1'b1;
        end else begin
          state_s = SHIFT;
          cnt_s   = cnt_r + CW'(1);
          shreg_s = shreg_adv_s;
          sout_s  = head_bit(shreg_adv_s);
          valid_s = 1'b1;
          ready_s = 1'b0;
        end
      end

      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
        shreg_s = {N{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      shreg_r <= {N{1'b0}};
      q_r     <= {N{1'b0}};
      sout_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shreg_r <= shreg_s;
      q_r     <= q_s;
      sout_r  <= sout_s;
      valid_r <= valid_s;
      done_r  <= done_s;
      ready_r <= ready_s;
    end
  end

  assign bus.ready = ready_r;
  assign bus.sout  = sout_r;
  assign bus.valid = valid_r;
  assign bus.done  = done_r;
  assign bus.q     = q_r;

endmodule

// File: tb/tb_reg_shift_tx.sv
// tb_reg_shift_tx
//   Self-checking bench for reg_shift_tx (N = 8). Every cycle is compared
//   against a schedule-based reference model; a cycle table and a few
//   hand-written sequences check the documented scenarios, and a random
//   phase exercises loads, idles and resets.
module tb_reg_shift_tx;

  localparam int N = 8;

  logic ck;
  logic rst;

  int tests_run;
  int tests_failed;

  reg_shift_tx_if #(.N(N)) bus ();

  reg_shift_tx #(.N(N)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus.slave)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Reference model: the item shown after each edge.
  // -1 idle, 0/1 word bit, 2 done cycle. sched holds the items still to come.
  int         cur;
  int         sched[$];
  logic [7:0] mq;

  // i-th transmitted bit of a word.
  function automatic int tx_bit(input logic [7:0] w, input int i);
`ifdef LSB_FIRST_EN
    return int'(w[i]);
`else
    return int'(w[7-i]);
`endif
  endfunction

  // Transmitted sequence packed first-bit-in-MSB, as a shift-in collector sees it.
  function automatic logic [7:0] exp_serial(input logic [7:0] w);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r = {r[6:0], 1'(tx_bit(w, i))};
    return r;
  endfunction

  function automatic logic [11:0] model_exp();
    logic is_bit;
    is_bit = (cur == 0) || (cur == 1);
    return {!is_bit, is_bit, (cur == 1), (cur == 2), mq};
  endfunction

  task automatic model_edge(input logic r, input logic ll, input logic [7:0] dd);
    if (r) begin
      cur = -1;
      sched.delete();
      mq  = 8'h00;
    end else if (cur == 0 || cur == 1) begin
      cur = sched.pop_front();
    end else if (ll) begin
      mq = dd;
      sched.delete();
      for (int i = 1; i < 8; i++) sched.push_back(tx_bit(dd, i));
      sched.push_back(2);
      cur = tx_bit(dd, 0);
    end else begin
      cur = -1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [11:0] dut_obs();
    return {bus.ready, bus.valid, bus.sout, bus.done, bus.q};
  endfunction

  // Apply inputs for one edge, advance the model, compare just after the edge.
  task automatic cycle(input logic r, input logic ll, input logic [7:0] dd);
    rst   = r;
    bus.l = ll;
    bus.d = dd;
    @(posedge ck);
    model_edge(r, ll, dd);
    #1;
    check("model {ready,valid,sout,done,q}", 32'(dut_obs()), 32'(model_exp()));
  endtask

  typedef struct {
    logic        r;
    logic        l;
    logic [7:0]  d;
    logic [11:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] seq_exp;
  logic [7:0] got;
  logic       v_tr[17];
  logic       s_tr[17];
  logic       dn_tr[17];
  int         vcnt;
  int         pulses;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cur          = -1;
    mq           = 8'h00;
    rst          = 1'b1;
    bus.l        = 1'b0;
    bus.d        = 8'h00;

    // ---------------- cycle table: reset with load, then one word 8'h03
`ifdef LSB_FIRST_EN
    seq_exp = 8'b11000000;   // sout order 1,1,0,0,0,0,0,0
`else
    seq_exp = 8'b00000011;   // sout order 0,0,0,0,0,0,1,1
`endif
    tbl.push_back('{1'b1, 1'b1, 8'hFF, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}});
    tbl.push_back('{1'b1, 1'b1, 8'hFF, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}});
    tbl.push_back('{1'b0, 1'b0, 8'hFF, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b0, (i == 0), (i == 0) ? 8'h03 : 8'h00,
                      {1'b0, 1'b1, seq_exp[7-i], 1'b0, 8'h03}});
    tbl.push_back('{1'b0, 1'b0, 8'h00, {1'b1, 1'b0, 1'b0, 1'b1, 8'h03}});
    tbl.push_back('{1'b0, 1'b0, 8'h00, {1'b1, 1'b0, 1'b0, 1'b0, 8'h03}});

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].l, tbl[i].d);
      check($sformatf("table row %0d", i), 32'(dut_obs()), 32'(tbl[i].exp));
    end

    // ---------------- load ignored while busy, d changes ignored
    got  = 8'h00;
    vcnt = 0;
    cycle(1'b0, 1'b1, 8'h0F);
    if (bus.valid) begin got = {got[6:0], bus.sout}; vcnt++; end
    for (int i = 1; i < 10; i++) begin
      cycle(1'b0, (i == 3), (i == 3) ? 8'hAA : 8'(i * 37));
      if (bus.valid) begin got = {got[6:0], bus.sout}; vcnt++; end
      if (i == 8) check("busy done pulse", 32'(bus.done), 32'd1);
    end
    check("busy bits", 32'(got), 32'(exp_serial(8'h0F)));
    check("busy valid count", 32'(vcnt), 32'd8);
    check("busy q held", 32'(bus.q), 32'h0F);

    // ---------------- back-to-back with l held high
    cycle(1'b0, 1'b1, 8'hA5);
    v_tr[0] = bus.valid; s_tr[0] = bus.sout; dn_tr[0] = bus.done;
    for (int i = 1; i < 17; i++) begin
      cycle(1'b0, 1'b1, 8'h3C);
      v_tr[i] = bus.valid; s_tr[i] = bus.sout; dn_tr[i] = bus.done;
    end
    got = 8'h00; vcnt = 0;
    for (int i = 0; i < 8; i++) begin got = {got[6:0], s_tr[i]}; vcnt += int'(v_tr[i]); end
    check("b2b burst1 bits", 32'(got), 32'(exp_serial(8'hA5)));
    check("b2b burst1 valid", 32'(vcnt), 32'd8);
    check("b2b gap {valid,done}", 32'({v_tr[8], dn_tr[8]}), 32'b01);
    got = 8'h00; vcnt = 0;
    for (int i = 9; i < 17; i++) begin got = {got[6:0], s_tr[i]}; vcnt += int'(v_tr[i]); end
    check("b2b burst2 bits", 32'(got), 32'(exp_serial(8'h3C)));
    check("b2b burst2 valid", 32'(vcnt), 32'd8);
    check("b2b q", 32'(bus.q), 32'h3C);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);

    // ---------------- reset after 3 bits of 8'hF0
    cycle(1'b0, 1'b1, 8'hF0);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("mid-word still busy", 32'(bus.valid), 32'd1);
    cycle(1'b1, 1'b0, 8'h00);
    check("mid-word reset state", 32'(dut_obs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 8'h00);
      pulses += int'(bus.done);
    end
    check("no done after abort", 32'(pulses), 32'd0);

    // ---------------- reset beats a load in the same cycle
    cycle(1'b1, 1'b1, 8'h5A);
    check("rst beats load", 32'(dut_obs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));

    // ---------------- randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_shift_tx.md
REG_SHIFT_TX -- requirements
Module: reg_shift_tx

Interface
REQ-001 SHALL have parameter: N, default 8, word width in bits (N >= 2).
REQ-002 SHALL have port: ck  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: l  input  1  load request; word on d is accepted when l=1 and ready=1.
REQ-005 SHALL have port: d  input  N  parallel data word to transmit.
REQ-006 SHALL have port: ready  output  1  1 = idle, able to accept a load.
REQ-007 SHALL have port: sout  output  1  serial data bit, registered.
REQ-008 SHALL have port: valid  output  1  1 while sout carries a word bit.
REQ-009 SHALL have port: done  output  1  one-cycle pulse after the last bit of a word.
REQ-010 SHALL have port: q  output  N  copy of the last accepted word, held until the next accept.

Function
REQ-011 SHALL implement FSM with states IDLE and SHIFT, plus a bit counter of width clog2(N).
REQ-012 In IDLE: ready=1, valid=0, sout=0.
REQ-013 IDLE with l=1 at a rising edge: capture d into the shift register and q, counter=0, go to SHIFT.
REQ-014 IDLE with l=0: hold state; q unchanged.
REQ-015 In SHIFT: ready=0, valid=1, sout = current bit; one bit per cycle; counter increments each cycle.
REQ-016 Word accepted at edge k: first bit visible after edge k, last bit after edge k+N-1; valid high for exactly N cycles.
REQ-017 At the edge where counter=N-1: go to IDLE, assert done for the following cycle (done coincides with ready=1, valid=0).
REQ-018 l asserted during SHIFT SHALL be ignored; d changes during SHIFT SHALL NOT affect the word in flight.
REQ-019 l=1 in the cycle where done=1 (state IDLE) SHALL be accepted; back-to-back words leave exactly one idle cycle between valid bursts.
REQ-020 Default bit order: MSB first (d[N-1] first, d[0] last).
REQ-021 All outputs SHALL be registered; no combinational path from l or d to any output.

Reset
REQ-022 rst=1 at a rising edge: state=IDLE, counter=0, shift register=0, q=0, sout=0, valid=0, done=0, ready=1.
REQ-023 rst SHALL take priority over l, including l=1 in the same cycle (load is discarded).
REQ-024 rst during SHIFT SHALL abort the word immediately; no done pulse is generated for the aborted word.

Configuration
REQ-025 Macro LSB_FIRST_EN: when defined, bit order is LSB first (d[0] first, d[N-1] last).
REQ-026 When LSB_FIRST_EN is not defined, bit order is MSB first per REQ-020; timing is identical in both builds.

Verification
REQ-027 Reset: rst=1 for 2 cycles with l=1, d=8'hFF -> q=8'h00, ready=1, valid=0, sout=0, done=0.
REQ-028 Single word: l=1, d=8'b00000011 for one cycle -> q=8'b00000011; sout sequence 0,0,0,0,0,0,1,1 with valid=1 for 8 cycles; then done=1 for 1 cycle, ready=1.
REQ-029 Ignore load while busy: during SHIFT of 8'b00001111, pulse l=1 with d=8'hAA -> sout sequence 0,0,0,0,1,1,1,1 unchanged; q stays 8'b00001111.
REQ-030 Back-to-back: l held at 1, d=8'hA5 then 8'h3C -> two 8-bit bursts 1,0,1,0,0,1,0,1 and 0,0,1,1,1,1,0,0, separated by exactly one cycle with valid=0 and done=1.
REQ-031 Reset mid-word: assert rst after 3 bits of 8'hF0 -> next cycle valid=0, sout=0, ready=1, q=8'h00; done stays 0.
REQ-032 LSB_FIRST_EN build: l=1, d=8'b00000011 -> sout sequence 1,1,0,0,0,0,0,0, then done=1.
